// File: rtl/lisnoc_router_output_arbiter.sv
// lisnoc_router_output_arbiter
// Per-output switch arbiter and link driver. This module grants one input
// port at a time in round-robin order and holds the grant for a whole
// packet. Granted flits are registered onto the link, which uses a
// valid/ready handshake.
//
// Build option: LISNOC_ROUTER_OUTPUT_SKID_EN
//   defined   - 2-entry output buffer. Accept depends only on registered
//               state, so there is no combinational path link_ready -> switch_read.
//   undefined - 1-entry output register. Accept = !link_valid || link_ready.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// st_idle   | no packet in flight; round-robin search from rr_q+1
// st_locked | owner_q holds the output until its LAST flit is captured

module lisnoc_router_output_arbiter #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int ports           = 5
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [ports-1:0]                                     switch_request,
  input  logic [(flit_data_width+flit_type_width)*ports-1:0]   switch_flit,
  output logic [ports-1:0]                                     switch_read,
  output logic [flit_data_width+flit_type_width-1:0]           link_flit,
  output logic                                                 link_valid,
  input  logic                                                 link_ready
);

  localparam int flit_width = flit_data_width + flit_type_width;
  localparam int ptr_width  = (ports > 1) ? $clog2(ports) : 1;

  localparam logic [1:0] type_payload = 2'b00;
  localparam logic [1:0] type_header  = 2'b01;
  localparam logic [1:0] type_last    = 2'b10;

  typedef enum logic {st_idle, st_locked} state_t;

  state_t                 state_q, state_d;
  logic [ptr_width-1:0]   owner_q, owner_d;
  logic [ptr_width-1:0]   rr_q, rr_d;
  logic [ptr_width-1:0]   rr_winner;
  logic [ptr_width-1:0]   sel;
  logic                   rr_found;
  logic                   accept;
  logic                   capture;
  logic [flit_width-1:0]  idle_flit;
  logic [flit_width-1:0]  lock_flit;
  logic [flit_width-1:0]  cap_flit;
  logic [1:0]             cap_type;

  // Round-robin search: first requester after rr_q. Port rr_q is checked last.
  always_comb begin
    logic [ptr_width-1:0] cand;
    cand      = '0;
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int k = 1; k <= ports; k++) begin
      cand = ptr_width'((int'(rr_q) + k) % ports);
      if (!rr_found && switch_request[cand]) begin
        rr_found  = 1'b1;
        rr_winner = cand;
      end
    end
  end

  // The winner flit and the owner flit are muxed separately, so the type
  // decode does not depend on the grant decision that it steers.
  assign idle_flit = switch_flit[int'(rr_winner)*flit_width +: flit_width];
  assign lock_flit = switch_flit[int'(owner_q)*flit_width +: flit_width];
  assign cap_flit  = (state_q == st_locked) ? lock_flit : idle_flit;
  assign cap_type  = cap_flit[flit_width-1 -: 2];

  // Next-state, grant and capture decision. Reads are suppressed during reset.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    capture     = 1'b0;
    sel         = rr_winner;
    switch_read = '0;
    case (state_q)
      st_idle: begin
        if (!rst && rr_found && accept) begin
          capture = 1'b1;
          sel     = rr_winner;
          rr_d    = rr_winner;
          if (cap_type == type_header || cap_type == type_payload) begin
            state_d = st_locked;
            owner_d = rr_winner;
          end
        end
      end
      st_locked: begin
        sel = owner_q;
        // HEADER/SINGLE from the owner are forwarded as-is; only LAST unlocks.
        if (!rst && switch_request[owner_q] && accept) begin
          capture = 1'b1;
          if (cap_type == type_last) begin
            state_d = st_idle;
          end
        end
      end
      default: begin
        state_d = st_idle;
      end
    endcase
    if (capture) begin
      switch_read[sel] = 1'b1;
    end
  end

  // Arbiter state register. rr_q resets to the last port so that port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= st_idle;
      owner_q <= '0;
      rr_q    <= ptr_width'(ports - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

`ifdef LISNOC_ROUTER_OUTPUT_SKID_EN

  logic [1:0]            count_q;
  logic [flit_width-1:0] skid_q;
  logic                  pop;

  assign accept     = (count_q != 2'd2);
  assign link_valid = (count_q != 2'd0);
  assign pop        = link_valid && link_ready;

  // Two-entry FIFO: link_flit is the head and skid_q holds the second entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      link_flit <= '0;
      skid_q    <= '0;
    end else begin
      case ({capture, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            link_flit <= cap_flit;
          end else begin
            skid_q <= cap_flit;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          link_flit <= skid_q;
          count_q   <= count_q - 2'd1;
        end
        2'b11: begin
          // The buffer is never full here (accept would be low), so it holds one entry.
          link_flit <= cap_flit;
        end
        default: begin
        end
      endcase
    end
  end

`else

  assign accept = !link_valid || link_ready;

  // Single output register. It is refilled in the same cycle as it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      link_valid <= 1'b0;
      link_flit  <= '0;
    end else if (capture) begin
      link_valid <= 1'b1;
      link_flit  <= cap_flit;
    end else if (link_ready) begin
      link_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_lisnoc_router_output_arbiter.sv
// Testbench for lisnoc_router_output_arbiter. It uses a behavioural arbiter
// model and a scoreboard of flits expected on the link.
// LISNOC_ROUTER_OUTPUT_SKID_EN selects the matching buffer depth model.

module tb_lisnoc_router_output_arbiter;

  localparam int fdw = 32;
  localparam int ftw = 2;
  localparam int np  = 5;
  localparam int fw  = fdw + ftw;

  localparam logic [1:0] t_payload = 2'b00;
  localparam logic [1:0] t_header  = 2'b01;
  localparam logic [1:0] t_last    = 2'b10;
  localparam logic [1:0] t_single  = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [np-1:0]     switch_request;
  logic [fw*np-1:0]  switch_flit;
  logic [np-1:0]     switch_read;
  logic [fw-1:0]     link_flit;
  logic              link_valid;
  logic              link_ready;

  lisnoc_router_output_arbiter #(
    .flit_data_width(fdw),
    .flit_type_width(ftw),
    .ports(np)
  ) dut (
    .clk(clk),
    .rst(rst),
    .switch_request(switch_request),
    .switch_flit(switch_flit),
    .switch_read(switch_read),
    .link_flit(link_flit),
    .link_valid(link_valid),
    .link_ready(link_ready)
  );

  always #5 clk = ~clk;

  logic [fw-1:0] src_q [np][$];
  logic [fw-1:0] sb[$];
  int            grant_log[$];
  logic [np-1:0] stall;
  int            n_checks = 0;
  int            n_errors = 0;
  int            pkt_id = 0;

  bit            m_locked;
  int            m_owner;
  int            m_rr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic add_pkt(input int port, input int len);
    logic [fdw-1:0] d;
    logic [1:0]     ty;
    for (int j = 0; j < len; j++) begin
      d  = {8'(port), 8'(pkt_id), 16'(j)};
      ty = (len == 1) ? t_single : (j == 0) ? t_header : (j == len - 1) ? t_last : t_payload;
      src_q[port].push_back({ty, d});
    end
    pkt_id++;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < np; i++) begin
      switch_request[i] = (src_q[i].size() > 0) && !stall[i];
      switch_flit[i*fw +: fw] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  // One clock cycle: drive, predict, compare, advance the model, then clock.
  task automatic step();
    int            exp_port;
    logic [np-1:0] exp_read;
    bit            acc;
    bit            pop;
    logic [fw-1:0] f;
    logic [1:0]    ty;
    drive_inputs();
    #1;
`ifdef LISNOC_ROUTER_OUTPUT_SKID_EN
    acc = (sb.size() < 2);
`else
    acc = (sb.size() == 0) || link_ready;
`endif
    exp_port = -1;
    exp_read = '0;
    if (acc) begin
      if (m_locked) begin
        if (switch_request[m_owner]) exp_port = m_owner;
      end else begin
        for (int k = 1; k <= np; k++) begin
          int p;
          p = (m_rr + k) % np;
          if (exp_port < 0 && switch_request[p]) exp_port = p;
        end
      end
    end
    if (exp_port >= 0) exp_read[exp_port] = 1'b1;
    chk("switch_read", 64'(switch_read), 64'(exp_read));
    chk("link_valid", 64'(link_valid), 64'(sb.size() > 0));
    if (sb.size() > 0) chk("link_flit", 64'(link_flit), 64'(sb[0]));
    pop = (sb.size() > 0) && link_ready;
    if (pop) sb.delete(0);
    if (exp_port >= 0) begin
      f  = src_q[exp_port].pop_front();
      ty = f[fw-1 -: 2];
      sb.push_back(f);
      grant_log.push_back(exp_port);
      if (!m_locked) begin
        m_rr = exp_port;
        if (ty == t_header || ty == t_payload) begin
          m_locked = 1'b1;
          m_owner  = exp_port;
        end
      end else if (ty == t_last) begin
        m_locked = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int max_cycles);
    int  n;
    bit  busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < max_cycles) begin
      busy = (sb.size() > 0);
      for (int i = 0; i < np; i++) if (src_q[i].size() > 0) busy = 1'b1;
      if (busy) begin
        step();
        n++;
      end
    end
    if (busy) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_inputs();
    #1;
    chk("read_in_reset", 64'(switch_read), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = np - 1;
    sb.delete();
    grant_log.delete();
    chk("valid_after_reset", 64'(link_valid), 64'd0);
    chk("flit_after_reset", 64'(link_flit), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    link_ready = 1'b1;
    stall = '0;
    switch_request = '0;
    switch_flit = '0;
    repeat (2) @(posedge clk);
    #1;

    // Single flit from port 2 right after reset.
    do_reset();
    src_q[2].push_back({t_single, 32'h11});
    step();
    chk("t1_flit", 64'(link_flit), 64'({t_single, 32'h11}));
    chk("t1_valid", 64'(link_valid), 64'd1);
    run_until_idle(20);

    // Two 3-flit packets that compete, followed by wormhole ordering.
    do_reset();
    add_pkt(0, 3);
    add_pkt(3, 3);
    run_until_idle(30);
    chk("t2_grants", 64'(grant_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("t2_order", 64'(grant_log[i]), (i < 3) ? 64'd0 : 64'd3);

    // All ports stream SINGLE flits, so grants follow strict round robin.
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < np; p++) add_pkt(p, 1);
    run_until_idle(60);
    chk("t3_grants", 64'(grant_log.size()), 64'd20);
    for (int i = 0; i < 20 && i < grant_log.size(); i++)
      chk("t3_order", 64'(grant_log[i]), 64'(i % np));

    // The owner stalls mid-packet, and the competing port must wait.
    do_reset();
    add_pkt(1, 3);
    add_pkt(4, 1);
    step();
    stall[1] = 1'b1;
    repeat (3) step();
    stall[1] = 1'b0;
    run_until_idle(30);
    chk("t4_grants", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      chk("t4_owner_last", 64'(grant_log[2]), 64'd1);
      chk("t4_then_port4", 64'(grant_log[3]), 64'd4);
    end

    // Link back-pressure for 4 cycles during a packet.
    do_reset();
    add_pkt(0, 6);
    add_pkt(2, 2);
    repeat (2) step();
    link_ready = 1'b0;
    repeat (4) step();
    link_ready = 1'b1;
    run_until_idle(40);
    chk("t5_grants", 64'(grant_log.size()), 64'd8);

    // Reset in the middle of a packet drops the lock.
    do_reset();
    add_pkt(0, 3);
    step();
    src_q[0].delete();
    do_reset();
    add_pkt(3, 1);
    step();
    chk("t6_grants", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() == 1) chk("t6_port3", 64'(grant_log[0]), 64'd3);
    run_until_idle(20);

    // Random traffic, stalls and back-pressure.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int p;
      p = int'($urandom_range(np - 1));
      if (src_q[p].size() < 6 && $urandom_range(2) == 0) add_pkt(p, int'($urandom_range(4, 1)));
      for (int i = 0; i < np; i++) stall[i] = ($urandom_range(4) == 0);
      link_ready = ($urandom_range(9) < 7);
      step();
    end
    stall = '0;
    link_ready = 1'b1;
    run_until_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
